// File: rtl/term_issue_queue.sv
// Age-ordered, collapsing issue queue for terminate micro-ops.
// Index 0 is the oldest entry; the lowest-index ready entry is issued.
module term_issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [3:0]       enq_opcode,
  input  logic [7:0]       enq_offset,
  input  logic [3:0]       enq_immediate,
  input  logic [TAG_W-1:0] enq_base_tag,
  input  logic             enq_base_rdy,
  input  logic [TAG_W-1:0] enq_flag_tag,
  input  logic             enq_flag_rdy,
  input  logic [4:0]       enq_rob,
  input  logic [7:0]       enq_arch_dest,
  input  logic [9:0]       enq_phys_dest,
  input  logic             wake_valid,
  input  logic [TAG_W-1:0] wake_tag,
  input  logic             flush,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [3:0]       iss_opcode,
  output logic [7:0]       iss_offset,
  output logic [3:0]       iss_immediate,
  output logic [TAG_W-1:0] iss_base_tag,
  output logic [TAG_W-1:0] iss_flag_tag,
  output logic [4:0]       iss_rob,
  output logic [7:0]       iss_arch_dest,
  output logic [9:0]       iss_phys_dest,
  output logic [3:0]       count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic             valid;
    logic             base_rdy;
    logic             flag_rdy;
    logic [3:0]       opcode;
    logic [7:0]       offset;
    logic [3:0]       immediate;
    logic [TAG_W-1:0] base_tag;
    logic [TAG_W-1:0] flag_tag;
    logic [4:0]       rob;
    logic [7:0]       arch_dest;
    logic [9:0]       phys_dest;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           woken [DEPTH+1];
  entry_t           new_ent;
  logic [3:0]       count_q, count_d;
  logic [DEPTH-1:0] rdy;
  logic [IDX_W-1:0] sel;
  logic             any_rdy;
  logic             iss_fire, enq_fire;
  logic [3:0]       wpos;

  always_comb begin
    rdy     = '0;
    sel     = '0;
    any_rdy = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rdy[i] = ent_q[i].valid & ent_q[i].base_rdy & (ent_q[i].flag_rdy | ent_q[i].opcode[0]);
      if (rdy[i] && !any_rdy) begin
        sel     = IDX_W'(i);
        any_rdy = 1'b1;
      end
    end
  end

  assign enq_ready = (count_q < 4'(DEPTH));
  assign iss_valid = any_rdy & ~flush;
  assign iss_fire  = iss_valid & iss_ready;
  assign enq_fire  = enq_valid & enq_ready & ~flush;
  assign wpos      = count_q - {3'b000, iss_fire};
  assign count     = count_q;

  assign iss_opcode    = ent_q[sel].opcode;
  assign iss_offset    = ent_q[sel].offset;
  assign iss_immediate = ent_q[sel].immediate;
  assign iss_base_tag  = ent_q[sel].base_tag;
  assign iss_flag_tag  = ent_q[sel].flag_tag;
  assign iss_rob       = ent_q[sel].rob;
  assign iss_arch_dest = ent_q[sel].arch_dest;
  assign iss_phys_dest = ent_q[sel].phys_dest;

  always_comb begin
    new_ent           = '0;
    new_ent.valid     = 1'b1;
    new_ent.base_rdy  = enq_base_rdy | (wake_valid & (enq_base_tag == wake_tag));
    new_ent.flag_rdy  = enq_flag_rdy | (wake_valid & (enq_flag_tag == wake_tag));
    new_ent.opcode    = enq_opcode;
    new_ent.offset    = enq_offset;
    new_ent.immediate = enq_immediate;
    new_ent.base_tag  = enq_base_tag;
    new_ent.flag_tag  = enq_flag_tag;
    new_ent.rob       = enq_rob;
    new_ent.arch_dest = enq_arch_dest;
    new_ent.phys_dest = enq_phys_dest;
  end

  // Wakeup is applied before collapsing so a shifted entry keeps its new rdy bits;
  // the extra top slot is an empty entry that shifts into the vacated position.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      woken[i] = ent_q[i];
      if (wake_valid && ent_q[i].valid && (ent_q[i].base_tag == wake_tag))
        woken[i].base_rdy = 1'b1;
      if (wake_valid && (ent_q[i].flag_tag == wake_tag))
        woken[i].flag_rdy = 1'b1;
    end
    woken[DEPTH] = '0;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (iss_fire && (IDX_W'(i) >= sel))
        ent_d[i] = woken[i+1];
      else
        ent_d[i] = woken[i];
      if (enq_fire && (4'(i) == wpos))
        ent_d[i] = new_ent;
      if (flush)
        ent_d[i].valid = 1'b0;
    end

    if (flush)
      count_d = '0;
    else
      count_d = count_q + {3'b000, enq_fire} - {3'b000, iss_fire};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        ent_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++)
        ent_q[i] <= ent_d[i];
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_term_issue_queue.sv
// Directed bench for term_issue_queue: a queue-based reference model checked
// every cycle, plus literal expectations on issue order and counts.
module tb_term_issue_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic             clk, rst;
  logic             enq_valid, enq_ready;
  logic [3:0]       enq_opcode;
  logic [7:0]       enq_offset;
  logic [3:0]       enq_immediate;
  logic [TAG_W-1:0] enq_base_tag, enq_flag_tag;
  logic             enq_base_rdy, enq_flag_rdy;
  logic [4:0]       enq_rob;
  logic [7:0]       enq_arch_dest;
  logic [9:0]       enq_phys_dest;
  logic             wake_valid;
  logic [TAG_W-1:0] wake_tag;
  logic             flush;
  logic             iss_valid, iss_ready;
  logic [3:0]       iss_opcode;
  logic [7:0]       iss_offset;
  logic [3:0]       iss_immediate;
  logic [TAG_W-1:0] iss_base_tag, iss_flag_tag;
  logic [4:0]       iss_rob;
  logic [7:0]       iss_arch_dest;
  logic [9:0]       iss_phys_dest;
  logic [3:0]       count;

  term_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_opcode(enq_opcode), .enq_offset(enq_offset), .enq_immediate(enq_immediate),
    .enq_base_tag(enq_base_tag), .enq_base_rdy(enq_base_rdy),
    .enq_flag_tag(enq_flag_tag), .enq_flag_rdy(enq_flag_rdy),
    .enq_rob(enq_rob), .enq_arch_dest(enq_arch_dest), .enq_phys_dest(enq_phys_dest),
    .wake_valid(wake_valid), .wake_tag(wake_tag), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_opcode(iss_opcode), .iss_offset(iss_offset), .iss_immediate(iss_immediate),
    .iss_base_tag(iss_base_tag), .iss_flag_tag(iss_flag_tag), .iss_rob(iss_rob),
    .iss_arch_dest(iss_arch_dest), .iss_phys_dest(iss_phys_dest),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] opc;
    logic [7:0] off;
    logic [3:0] imm;
    logic [4:0] bt, ft;
    logic       br, fr;
    logic [4:0] rob;
    logic [7:0] arch;
    logic [9:0] phys;
  } m_t;

  m_t         mq[$];
  logic [4:0] issued[$];

  function automatic logic [31:0] order();
    logic [31:0] r = 0;
    foreach (issued[i]) r = (r << 8) | 32'(issued[i]);
    return r;
  endfunction

  // Reference model: age-ordered list, compared then advanced at each falling edge.
  always @(negedge clk) begin
    int  sel;
    bit  found, ev, fire_e;
    m_t  n;
    sel = 0;
    found = 0;
    if (rst) begin
      mq.delete();
      chk("rst_count", 32'(count), 0);
      chk("rst_iss_valid", 32'(iss_valid), 0);
      chk("rst_enq_ready", 32'(enq_ready), 1);
    end else begin
      foreach (mq[i])
        if (!found && mq[i].br && (mq[i].fr || mq[i].opc[0])) begin
          found = 1;
          sel = i;
        end
      ev = found && !flush;
      chk("m_iss_valid", 32'(iss_valid), 32'(ev));
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_enq_ready", 32'(enq_ready), 32'(mq.size() < DEPTH));
      if (ev) begin
        chk("m_iss_rob", 32'(iss_rob), 32'(mq[sel].rob));
        chk("m_iss_opcode", 32'(iss_opcode), 32'(mq[sel].opc));
        chk("m_iss_offset", 32'(iss_offset), 32'(mq[sel].off));
        chk("m_iss_imm", 32'(iss_immediate), 32'(mq[sel].imm));
        chk("m_iss_btag", 32'(iss_base_tag), 32'(mq[sel].bt));
        chk("m_iss_ftag", 32'(iss_flag_tag), 32'(mq[sel].ft));
        chk("m_iss_arch", 32'(iss_arch_dest), 32'(mq[sel].arch));
        chk("m_iss_phys", 32'(iss_phys_dest), 32'(mq[sel].phys));
      end
      if (flush) mq.delete();
      else begin
        fire_e = enq_valid && (mq.size() < DEPTH);
        if (wake_valid)
          foreach (mq[i]) begin
            if (mq[i].bt == wake_tag) mq[i].br = 1;
            if (mq[i].ft == wake_tag) mq[i].fr = 1;
          end
        if (ev && iss_ready) begin
          issued.push_back(mq[sel].rob);
          mq.delete(sel);
        end
        if (fire_e) begin
          n.opc = enq_opcode; n.off = enq_offset; n.imm = enq_immediate;
          n.bt = enq_base_tag; n.ft = enq_flag_tag;
          n.br = enq_base_rdy || (wake_valid && enq_base_tag == wake_tag);
          n.fr = enq_flag_rdy || (wake_valid && enq_flag_tag == wake_tag);
          n.rob = enq_rob; n.arch = enq_arch_dest; n.phys = enq_phys_dest;
          mq.push_back(n);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input logic [4:0] rob, input logic [3:0] opc,
                         input logic [4:0] bt, input logic br,
                         input logic [4:0] ft, input logic fr);
    enq_valid     = 1'b1;
    enq_rob       = rob;
    enq_opcode    = opc;
    enq_base_tag  = bt;
    enq_base_rdy  = br;
    enq_flag_tag  = ft;
    enq_flag_rdy  = fr;
    enq_offset    = {rob, 3'b101};
    enq_immediate = rob[3:0] ^ 4'h5;
    enq_arch_dest = {3'b000, rob} + 8'h40;
    enq_phys_dest = {rob, rob};
  endtask

  task automatic enq_op(input logic [4:0] rob, input logic [3:0] opc,
                        input logic [4:0] bt, input logic br,
                        input logic [4:0] ft, input logic fr);
    set_enq(rob, opc, bt, br, ft, fr);
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic wake(input logic [4:0] t);
    wake_valid = 1'b1;
    wake_tag   = t;
    tick();
    wake_valid = 1'b0;
  endtask

  localparam logic [3:0] COND = 4'b0010;
  localparam logic [3:0] UNC  = 4'b0001;

  initial begin
    rst = 1'b1; enq_valid = 0; wake_valid = 0; wake_tag = '0; flush = 0; iss_ready = 0;
    set_enq(0, COND, 0, 0, 0, 0);
    enq_valid = 0;
    tick();
    chk("reset_count", 32'(count), 0);
    chk("reset_enq_ready", 32'(enq_ready), 1);
    tick();
    rst = 1'b0;

    // Four ready ops issue in order, back to back
    issued.delete();
    iss_ready = 1;
    for (int r = 1; r <= 4; r++) enq_op(5'(r), COND, 1, 1, 2, 1);
    chk("t1_iss_rob", 32'(iss_rob), 4);
    chk("t1_count_mid", 32'(count), 1);
    tick();
    chk("t1_count", 32'(count), 0);
    chk("t1_order", order(), 32'h01020304);

    // Fill with ops waiting on tag 7, then one wakeup releases all
    issued.delete();
    for (int r = 5; r <= 8; r++) enq_op(5'(r), COND, 7, 0, 9, 1);
    chk("t2_full_ready", 32'(enq_ready), 0);
    chk("t2_full_count", 32'(count), 4);
    enq_op(9, COND, 1, 1, 2, 1);
    chk("t2_drop_count", 32'(count), 4);
    wake_valid = 1; wake_tag = 7;
    #1 chk("t2_no_comb_wake", 32'(iss_valid), 0);
    tick();
    wake_valid = 0;
    chk("t2_iss_after_wake", 32'(iss_valid), 1);
    chk("t2_first_rob", 32'(iss_rob), 5);
    repeat (4) tick();
    chk("t2_order", order(), 32'h05060708);
    chk("t2_count", 32'(count), 0);

    // Unconditional younger op bypasses an older op waiting on flags
    issued.delete();
    enq_op(10, COND, 1, 1, 12, 0);
    enq_op(11, UNC,  1, 1, 13, 0);
    tick();
    chk("t3_unc_first", order(), 32'h0B);
    chk("t3_count", 32'(count), 1);
    wake(12);
    tick();
    chk("t3_order", order(), 32'h0B0A);

    // Same-cycle wakeup on enqueue
    issued.delete();
    wake_valid = 1; wake_tag = 3;
    enq_op(12, COND, 3, 0, 2, 1);
    wake_valid = 0;
    chk("t4_iss_valid", 32'(iss_valid), 1);
    chk("t4_iss_rob", 32'(iss_rob), 12);
    tick();
    chk("t4_order", order(), 32'h0C);

    // Simultaneous issue and enqueue at count 2
    issued.delete();
    iss_ready = 0;
    enq_op(13, COND, 1, 1, 2, 1);
    enq_op(14, COND, 1, 1, 2, 1);
    chk("t5_count2", 32'(count), 2);
    iss_ready = 1;
    enq_op(15, COND, 1, 1, 2, 1);
    chk("t5_count_same", 32'(count), 2);
    chk("t5_older_first", 32'(iss_rob), 14);
    repeat (2) tick();
    chk("t5_order", order(), 32'h0D0E0F);

    // Backpressure: selection stable, then switches to an older woken entry
    issued.delete();
    iss_ready = 0;
    enq_op(20, COND, 5, 0, 2, 1);
    enq_op(21, COND, 1, 1, 2, 1);
    chk("t6_sel_young", 32'(iss_rob), 21);
    tick();
    chk("t6_sel_stable", 32'(iss_rob), 21);
    wake(5);
    chk("t6_sel_old", 32'(iss_rob), 20);
    iss_ready = 1;
    repeat (2) tick();
    chk("t6_order", order(), 32'h1415);

    // Flush with a concurrent enqueue drops everything
    issued.delete();
    iss_ready = 0;
    for (int r = 16; r <= 18; r++) enq_op(5'(r), COND, 1, 1, 2, 1);
    chk("t7_count3", 32'(count), 3);
    set_enq(19, COND, 1, 1, 2, 1);
    flush = 1;
    #1 chk("t7_flush_iss", 32'(iss_valid), 0);
    tick();
    flush = 0; enq_valid = 0;
    chk("t7_flush_count", 32'(count), 0);
    tick();
    chk("t7_no_issue", order(), 0);

    // Asynchronous reset between edges
    enq_op(22, COND, 1, 1, 2, 1);
    enq_op(23, COND, 1, 1, 2, 1);
    chk("t8_count2", 32'(count), 2);
    #2 rst = 1;
    #1 chk("t8_async_count", 32'(count), 0);
    chk("t8_async_iss", 32'(iss_valid), 0);
    tick();
    rst = 0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/term_issue_queue.md
# term_issue_queue

Age-ordered issue queue and scheduler for the terminate (branch/jump resolution) pipeline. It accepts renamed terminate micro-ops from dispatch and holds them until their base-register and flag operands are produced. Each cycle it issues the oldest ready entry to the operand-read stage that feeds the terminate pipeline, using a valid/ready handshake. A flush from the ROB discards every held entry.

## Interface
Parameters:
- DEPTH, 4, number of queue entries (2..8)
- TAG_W, 5, physical register tag width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- enq_valid  in  1  dispatch offers a micro-op
- enq_ready  out  1  queue can accept (count < DEPTH)
- enq_opcode  in  4  terminate opcode; bit 0 = unconditional
- enq_offset  in  8  branch offset
- enq_immediate  in  4  condition selector or jump increment
- enq_base_tag  in  TAG_W  phys tag of base register
- enq_base_rdy  in  1  base operand already available
- enq_flag_tag  in  TAG_W  phys tag of flags register
- enq_flag_rdy  in  1  flags operand already available
- enq_rob  in  5  ROB entry
- enq_arch_dest  in  8  architectural destinations
- enq_phys_dest  in  10  physical destinations
- wake_valid  in  1  a physical register was written this cycle
- wake_tag  in  TAG_W  tag of the written register
- flush  in  1  discard all entries (synchronous)
- iss_valid  out  1  oldest ready entry presented
- iss_ready  in  1  downstream accepts
- iss_opcode, iss_offset, iss_immediate, iss_base_tag, iss_flag_tag, iss_rob, iss_arch_dest, iss_phys_dest  out  (widths as enq_*)  fields of the selected entry
- count  out  4  number of valid entries

## Operation
- Entry state: valid, base_rdy, flag_rdy, and the enq_* payload. Entries are collapsing and age-ordered: index 0 is the oldest, and valid entries occupy indices 0..count-1.
- Ready: an entry is ready when valid & base_rdy & (flag_rdy | opcode[0]). Unconditional ops never wait on flags.
- Select: the lowest-index ready entry. iss_valid = any ready & ~flush. The iss_* fields are driven combinationally from the selected entry's registers. With no ready entry, iss_* other than iss_valid hold the index-0 fields; their values are don't-care.
- Issue: fires when iss_valid & iss_ready. The selected entry is removed at the edge. Entries above it shift down one index, and count decrements.
- Enqueue: fires when enq_valid & enq_ready. The new entry is written at index count, or at count-1 if an issue fires in the same cycle. enq_ready depends only on registered count, so there is no same-cycle enqueue-on-full even if an issue frees a slot.
- Wakeup: when wake_valid is set, every valid entry with base_tag == wake_tag sets base_rdy, and every entry with flag_tag == wake_tag sets flag_rdy. An entry enqueued in the same cycle also matches against wake_tag: its stored rdy bit = enq_*_rdy | (wake_valid & tag match). Base and flag tags may be equal; both bits are set.
- Flush: on the next edge, all valid bits clear and count = 0. Flush overrides enqueue and issue in the same cycle; neither takes effect. iss_valid is forced low while flush is high.
- Invariants: count never exceeds DEPTH and never underflows. The issue order among ready entries is strictly oldest-first.

## Timing
- Reset: all valid bits 0, count = 0, iss_valid = 0, enq_ready = 1. Asserting rst mid-operation clears the queue immediately and asynchronously, regardless of the clock.
- Enqueue to issue: minimum 1 cycle. An op enqueued ready at edge N can present iss_valid in cycle N+1.
- Wakeup to issue: 1 cycle. A rdy bit set at edge N is visible to select in cycle N+1. There is no combinational wake_tag to iss_valid path.
- Throughput: one issue and one enqueue per cycle sustained while not full.
- Backpressure: while iss_ready is low, the selected entry and its iss_* fields stay stable, unless a wakeup makes an older entry ready. In that case the selection changes to the older entry the next cycle. Downstream must sample the fields only on a transfer.
- The issue handshake introduces no bubbles. Back-to-back ready entries issue on consecutive cycles.

## Test plan
- Reset, then enqueue 4 ready conditional ops (rob 1..4) with iss_ready = 1 -> issue order is rob 1,2,3,4 on consecutive cycles; count returns to 0; enq_ready stays 1.
- Fill with 4 ops whose base_tag = 7, not ready -> enq_ready = 0 at count = 4. Then pulse wake_tag = 7 -> iss_valid rises the next cycle, and all 4 issue oldest-first.
- Entry 0 is a conditional op with flag_rdy = 0; entry 1 is opcode 4'b0001 (unconditional) with flag_rdy = 0 and base ready -> entry 1 issues first. Entry 0 issues only after a wake_tag matching its flag_tag.
- Enqueue an op with base_tag = 3 and base_rdy = 0 in the same cycle as wake_tag = 3 -> the op is ready and issues the following cycle.
- Simultaneous issue and enqueue at count = 2 -> count stays 2, and the new op sits behind the remaining older op.
- With 3 entries, hold iss_ready = 0 and assert flush together with enq_valid -> iss_valid is 0 during flush, count = 0 next cycle, and the enqueued op is dropped. Separately, assert rst between edges -> count = 0 immediately.
